// File: rtl/crypto_pkg.sv
// Shared types for the 8-bit cryptosystem datapath.
package crypto_pkg;
  localparam int DATA_W = 8;
  typedef logic [DATA_W-1:0] byte_t;
endpackage

// File: rtl/xor_core.sv
// Pure combinational WIDTH-bit XOR; encrypt and decrypt are the same operation.
module xor_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/bitwise_xor.sv
// XOR datapath stage: combinational a ^ b, plus a one-deep registered,
// valid/ready path XORing a with either b or a stored key.
module bitwise_xor
  import crypto_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  input  logic             key_we,
  input  logic [WIDTH-1:0] key_in,
  input  logic             use_key,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_q,
  output logic             y_zero,
  output logic             y_parity
);

  logic [WIDTH-1:0] key_reg;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] y_next;
  logic             accept;

  // Direct path: no clock or reset dependence.
  xor_core #(.WIDTH(WIDTH)) u_xor_direct (
    .a (a),
    .b (b),
    .y (y)
  );

  // Key register is read before any same-cycle write, so a simultaneous
  // key load only affects later accepts.
  assign opnd = use_key ? key_reg : b;

  xor_core #(.WIDTH(WIDTH)) u_xor_reg (
    .a (a),
    .b (opnd),
    .y (y_next)
  );

  // Output slot is free when empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Key register, result register, flags and valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_reg   <= '0;
      y_q       <= '0;
      out_valid <= 1'b0;
      y_zero    <= 1'b0;
      y_parity  <= 1'b0;
    end else begin
      if (key_we) key_reg <= key_in;
      if (accept) begin
        y_q       <= y_next;
        y_zero    <= (y_next == '0);
        y_parity  <= ^y_next;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitwise_xor.sv
// Directed bench for bitwise_xor: combinational path, reset, key path,
// same-cycle key load, backpressure, streaming and mid-operation reset.
module tb_bitwise_xor;
  import crypto_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  byte_t a, b, y, key_in, y_q;
  logic  key_we, use_key, in_valid, in_ready, out_valid, out_ready, y_zero, y_parity;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bitwise_xor #(.WIDTH(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .y         (y),
    .key_we    (key_we),
    .key_in    (key_in),
    .use_key   (use_key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_q       (y_q),
    .y_zero    (y_zero),
    .y_parity  (y_parity)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] eq, input logic ev,
                         input logic ez, input logic ep);
    chk({tag, ".y_q"},       y_q,       eq);
    chk({tag, ".out_valid"}, out_valid, ev);
    chk({tag, ".y_zero"},    y_zero,    ez);
    chk({tag, ".y_parity"},  y_parity,  ep);
  endtask

  initial begin
    rst_n = 1'b0; a = '0; b = '0; key_we = 1'b0; key_in = '0;
    use_key = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // Combinational path, held in reset and before any clock edge
    a = 8'hAA; b = 8'h55; #1; chk("comb_aa_55", y, 8'hFF);
    a = 8'hF0; b = 8'h0F; #1; chk("comb_f0_0f", y, 8'hFF);
    a = 8'h00; b = 8'hFF; #1; chk("comb_00_ff", y, 8'hFF);
    a = 8'hFF; b = 8'hFF; #1; chk("comb_ff_ff", y, 8'h00);

    // Reset for two edges
    tick(); tick();
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset.in_ready", in_ready, 1'b1);
    a = 8'h12; b = 8'h34; #1; chk("reset.y_tracks", y, 8'h26);
    rst_n = 1'b1;

    // Key cleared by reset: a ^ key = a
    a = 8'h5A; use_key = 1'b1; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk_out("key_zero", 8'h5A, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("drain", 8'h5A, 1'b0, 1'b0, 1'b0);

    // Key path
    key_we = 1'b1; key_in = 8'h3C;
    tick(); key_we = 1'b0;
    a = 8'hC3; use_key = 1'b1; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk_out("key_path", 8'hFF, 1'b1, 1'b0, 1'b0);
    tick();
    chk("key_path.drain", out_valid, 1'b0);

    // Same-cycle key load: accept uses old key 3C
    key_we = 1'b1; key_in = 8'h00; a = 8'h3C; use_key = 1'b1; in_valid = 1'b1;
    tick(); key_we = 1'b0;
    chk_out("same_cycle_key", 8'h00, 1'b1, 1'b1, 1'b0);
    // Next accept sees key 00; also consume+accept together
    a = 8'h07;
    tick(); in_valid = 1'b0;
    chk_out("new_key", 8'h07, 1'b1, 1'b0, 1'b1);
    tick();
    chk("new_key.drain", out_valid, 1'b0);

    // Backpressure
    out_ready = 1'b0; use_key = 1'b0; a = 8'h11; b = 8'h22; in_valid = 1'b1;
    tick();
    chk_out("bp_first", 8'h33, 1'b1, 1'b0, 1'b0);
    chk("bp.in_ready_low", in_ready, 1'b0);
    a = 8'hF0; b = 8'h01;
    tick();
    chk_out("bp_hold1", 8'h33, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("bp_hold2", 8'h33, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b1; #1;
    chk("bp.in_ready_high", in_ready, 1'b1);
    tick(); in_valid = 1'b0;
    chk_out("bp_second", 8'hF1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("bp.drain", out_valid, 1'b0);

    // Streaming: one result per cycle, lagging inputs by one
    in_valid = 1'b1; use_key = 1'b0;
    a = 8'h01; b = 8'h02; tick(); chk_out("stream0", 8'h03, 1'b1, 1'b0, 1'b0);
    a = 8'h10; b = 8'h20; tick(); chk_out("stream1", 8'h30, 1'b1, 1'b0, 1'b0);
    a = 8'hFF; b = 8'h0F; tick(); chk_out("stream2", 8'hF0, 1'b1, 1'b0, 1'b0);
    a = 8'h80; b = 8'h00; tick(); chk_out("stream3", 8'h80, 1'b1, 1'b0, 1'b1);
    a = 8'h55; b = 8'h55; tick(); chk_out("stream4", 8'h00, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick(); chk("stream.drain", out_valid, 1'b0);

    // Reset mid-operation discards pending result and key
    key_we = 1'b1; key_in = 8'hAB; out_ready = 1'b0; a = 8'h0E; b = 8'h01; in_valid = 1'b1;
    tick(); key_we = 1'b0; in_valid = 1'b0;
    chk_out("pre_rst", 8'h0F, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_out("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; out_ready = 1'b1;
    a = 8'h11; use_key = 1'b1; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk_out("post_rst_key", 8'h11, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
